// File: rtl/dsp_mac_pkg.sv
// Shared types and constants for the dsp_mac_seq job sequencer and its
// interface: FSM state encoding, operand/result widths and DSP-port bundle.
package dsp_mac_pkg;

  localparam int RES_W = 27;
  localparam int OP_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } mac_state_e;

  typedef struct packed {
    logic [OP_W-1:0] ax;
    logic [OP_W-1:0] bx;
    logic [OP_W-1:0] ay;
    logic [OP_W-1:0] by;
    logic            accumulate;
  } dsp_ops_t;

  localparam dsp_ops_t DSP_ZERO = '{
    ax:         8'd0,
    bx:         8'd0,
    ay:         8'd0,
    by:         8'd0,
    accumulate: 1'b0
  };

  // A zero-latency datapath still needs a one-bit counter to exist.
  function automatic int drain_cnt_w(input int mac_lat);
    if (mac_lat < 1) begin
      return 1;
    end else begin
      return $clog2(mac_lat + 1);
    end
  endfunction

endpackage

// File: rtl/dsp_mac_seq_if.sv
// Command, operand-beat and result handshakes between a job producer
// (master) and the dsp_mac_seq sequencer (slave).
interface dsp_mac_seq_if
  import dsp_mac_pkg::*;
#(
  parameter int LEN_W = 8
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_a1;
  logic [OP_W-1:0]  in_b1;
  logic [OP_W-1:0]  in_a2;
  logic [OP_W-1:0]  in_b2;

  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_data;

  modport master (
    output cmd_valid, cmd_len,
    output in_valid, in_a1, in_b1, in_a2, in_b2,
    output res_ready,
    input  cmd_ready, in_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_len,
    input  in_valid, in_a1, in_b1, in_a2, in_b2,
    input  res_ready,
    output cmd_ready, in_ready, res_valid, res_data
  );

endinterface

// File: rtl/dsp_mac_seq_drain.sv
// Down-counter that times the external MAC pipeline after the last beat;
// done is high once MAC_LAT decrements have elapsed since load.
module dsp_mac_seq_drain
  import dsp_mac_pkg::*;
#(
  parameter int MAC_LAT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int               CNT_W    = drain_cnt_w(MAC_LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MAC_LAT);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: load wins over decrement, saturate at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_INIT;
    end else if (en && (cnt_q != CNT_ZERO)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/dsp_mac_seq.sv
// Dot-product job sequencer: accepts a length-N job, streams N operand beats
// into an external pipelined MAC, waits out its latency and returns the sum.
module dsp_mac_seq
  import dsp_mac_pkg::*;
#(
  parameter int MAC_LAT = 3,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  dsp_mac_seq_if.slave     bus,
  output logic [OP_W-1:0]  dsp_ax,
  output logic [OP_W-1:0]  dsp_bx,
  output logic [OP_W-1:0]  dsp_ay,
  output logic [OP_W-1:0]  dsp_by,
  output logic             dsp_accumulate,
  input  logic [RES_W-1:0] dsp_resulta
);

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [RES_W-1:0] RES_ZERO = {RES_W{1'b0}};

  mac_state_e       state_q,     state_d;
  logic [LEN_W-1:0] beat_cnt_q,  beat_cnt_d;
  logic             started_q,   started_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             in_ready_q,  in_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [RES_W-1:0] res_data_q,  res_data_d;
  dsp_ops_t         ops_q,       ops_d;

  logic beat_fire;
  logic drain_load;
  logic drain_en;
  logic drain_done;

  assign beat_fire = bus.in_valid & in_ready_q;

  dsp_mac_seq_drain #(
    .MAC_LAT (MAC_LAT)
  ) u_drain (
    .clk   (clk),
    .reset (reset),
    .load  (drain_load),
    .en    (drain_en),
    .done  (drain_done)
  );

  // next-state, job bookkeeping and next DSP operand word
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    started_d   = started_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    ops_d       = DSP_ZERO;
    drain_load  = 1'b0;
    drain_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        started_d = 1'b0;
        if (bus.cmd_valid && cmd_ready_q) begin
          beat_cnt_d = bus.cmd_len;
          if (bus.cmd_len == LEN_ZERO) begin
            state_d     = ST_HOLD;
            res_valid_d = 1'b1;
            res_data_d  = RES_ZERO;
          end else begin
            state_d = ST_FEED;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FEED: begin
        // bubbles after the first beat add zero; before it they load zero
        ops_d.accumulate = started_q;
        if (beat_fire) begin
          ops_d.ax   = bus.in_a1;
          ops_d.bx   = bus.in_b1;
          ops_d.ay   = bus.in_a2;
          ops_d.by   = bus.in_b2;
          started_d  = 1'b1;
          beat_cnt_d = beat_cnt_q - LEN_ONE;
          if (beat_cnt_q == LEN_ONE) begin
            state_d    = ST_DRAIN;
            drain_load = 1'b1;
          end else begin
            state_d = ST_FEED;
          end
        end else begin
          state_d = ST_FEED;
        end
      end

      ST_DRAIN: begin
        ops_d.accumulate = 1'b1;
        if (drain_done) begin
          res_data_d  = dsp_resulta;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          drain_en = 1'b1;
          state_d  = ST_DRAIN;
        end
      end

      ST_HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
        started_d   = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    in_ready_d  = (state_d == ST_FEED);
  end

  // state and registered outputs; reset discards any job in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= LEN_ZERO;
      started_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= RES_ZERO;
      ops_q       <= DSP_ZERO;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      started_q   <= started_d;
      cmd_ready_q <= cmd_ready_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      ops_q       <= ops_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign dsp_ax         = ops_q.ax;
  assign dsp_bx         = ops_q.bx;
  assign dsp_ay         = ops_q.ay;
  assign dsp_by         = ops_q.by;
  assign dsp_accumulate = ops_q.accumulate;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Directed bench for dsp_mac_seq with a 3-cycle MAC model and a result
// scoreboard checked by an independent monitor.
module tb_dsp_mac_seq;
  import dsp_mac_pkg::*;

  localparam int MAC_LAT = 3;
  localparam int LEN_W   = 8;
  localparam int BOUND   = 60;

  typedef struct {
    logic [26:0] data;
    int          cyc;
  } exp_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  dsp_ax, dsp_bx, dsp_ay, dsp_by;
  logic        dsp_accumulate;
  logic [26:0] dsp_resulta;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t sb_q[$];

  dsp_mac_seq_if #(.LEN_W(LEN_W)) bus();

  dsp_mac_seq #(.MAC_LAT(MAC_LAT), .LEN_W(LEN_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .dsp_ax         (dsp_ax),
    .dsp_bx         (dsp_bx),
    .dsp_ay         (dsp_ay),
    .dsp_by         (dsp_by),
    .dsp_accumulate (dsp_accumulate),
    .dsp_resulta    (dsp_resulta)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external MAC: operands driven at edge k reach the accumulator at edge k+3
  logic [17:0] p0_sum = 18'd0, p1_sum = 18'd0;
  logic        p0_acc = 1'b0,  p1_acc = 1'b0;
  logic [26:0] mac_acc = 27'd0;
  always @(posedge clk) begin
    p0_sum  <= 18'(dsp_ax) * 18'(dsp_bx) + 18'(dsp_ay) * 18'(dsp_by);
    p0_acc  <= dsp_accumulate;
    p1_sum  <= p0_sum;
    p1_acc  <= p0_acc;
    mac_acc <= p1_acc ? (mac_acc + 27'(p1_sum)) : 27'(p1_sum);
  end
  assign dsp_resulta = mac_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // result monitor: pops expectations, checks latency, stability and cmd_ready
  logic        prev_v = 1'b0;
  logic [26:0] held   = 27'd0;
  always @(negedge clk) begin
    if (bus.res_valid === 1'b1) begin
      if (!prev_v) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("res_data", 64'(bus.res_data), 64'(e.data));
          chk("res_latency_cycle", 64'(cyc), 64'(e.cyc));
        end
        held = bus.res_data;
      end else begin
        chk("res_data_stable", 64'(bus.res_data), 64'(held));
      end
      chk("cmd_ready_in_hold", 64'(bus.cmd_ready), 64'd0);
    end
    prev_v = (bus.res_valid === 1'b1);
  end

  task automatic send_cmd(input logic [7:0] len, output int c);
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
    if (n >= BOUND) chk("cmd_ready_timeout", 64'd1, 64'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = len;
    tick();
    c = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] a1, b1, a2, b2, output int e);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
    if (n >= BOUND) chk("in_ready_timeout", 64'd1, 64'd0);
    bus.in_valid = 1'b1;
    bus.in_a1 = a1; bus.in_b1 = b1; bus.in_a2 = a2; bus.in_b2 = b2;
    tick();
    e = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [26:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  initial begin
    int c, e, n;
    bus.cmd_valid = 1'b0; bus.cmd_len = 8'd0;
    bus.in_valid  = 1'b0;
    bus.in_a1 = 8'd0; bus.in_b1 = 8'd0; bus.in_a2 = 8'd0; bus.in_b2 = 8'd0;
    bus.res_ready = 1'b1;

    // reset state
    tick(); tick();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_res_data", 64'(bus.res_data), 64'd0);
    chk("rst_dsp_acc", 64'(dsp_accumulate), 64'd0);
    chk("rst_dsp_ax", 64'(dsp_ax), 64'd0);
    reset = 1'b0;
    tick();
    chk("cmd_ready_after_rst", 64'(bus.cmd_ready), 64'd1);

    // single beat 3*4+5*6 = 42
    send_cmd(8'd1, c);
    chk("pre_beat_dsp_acc", 64'(dsp_accumulate), 64'd0);
    send_beat(8'd3, 8'd4, 8'd5, 8'd6, e);
    push_exp(27'd42, e + MAC_LAT + 1);
    chk("first_beat_acc", 64'(dsp_accumulate), 64'd0);
    chk("first_beat_ax", 64'(dsp_ax), 64'd3);
    chk("first_beat_by", 64'(dsp_by), 64'd6);
    chk("in_ready_after_last", 64'(bus.in_ready), 64'd0);

    // four full-scale beats, then an extra beat offered that must be refused
    send_cmd(8'd4, c);
    for (int i = 0; i < 4; i++) begin
      send_beat(8'd255, 8'd255, 8'd255, 8'd255, e);
      if (i == 1) chk("later_beat_acc", 64'(dsp_accumulate), 64'd1);
    end
    push_exp(27'd520200, e + MAC_LAT + 1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("no_extra_beat", 64'(bus.in_ready), 64'd0);
      tick();
    end
    bus.in_valid = 1'b0;

    // bubbles between beat 1 and 2: 3 beats of 1*1+1*1 = 6
    send_cmd(8'd3, c);
    send_beat(8'd1, 8'd1, 8'd1, 8'd1, e);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bubble_acc", 64'(dsp_accumulate), 64'd1);
      chk("bubble_ops", 64'({dsp_ax, dsp_bx, dsp_ay, dsp_by}), 64'd0);
    end
    send_beat(8'd1, 8'd1, 8'd1, 8'd1, e);
    send_beat(8'd1, 8'd1, 8'd1, 8'd1, e);
    push_exp(27'd6, e + MAC_LAT + 1);

    // zero-length job: result 0 in the cycle after the command
    send_cmd(8'd0, c);
    push_exp(27'd0, c);
    chk("len0_res_valid", 64'(bus.res_valid), 64'd1);
    chk("len0_dsp_acc", 64'(dsp_accumulate), 64'd0);
    tick();
    chk("len0_dsp_acc_next", 64'(dsp_accumulate), 64'd0);

    // result back-pressure: 10*10+2*3 = 106 held, pending command waits
    bus.res_ready = 1'b0;
    send_cmd(8'd1, c);
    send_beat(8'd10, 8'd10, 8'd2, 8'd3, e);
    push_exp(27'd106, e + MAC_LAT + 1);
    n = 0;
    while (bus.res_valid !== 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
    if (n >= BOUND) chk("res_valid_timeout", 64'd1, 64'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_res_valid", 64'(bus.res_valid), 64'd1);
      chk("hold_no_job", 64'(bus.in_ready), 64'd0);
    end
    bus.res_ready = 1'b1;
    tick();
    chk("res_valid_after_ready", 64'(bus.res_valid), 64'd0);
    send_cmd(8'd1, c);
    chk("job_after_handshake", 64'(bus.in_ready), 64'd1);
    send_beat(8'd2, 8'd3, 8'd4, 8'd5, e);
    push_exp(27'd26, e + MAC_LAT + 1);

    // abort after 2 of 4 beats; the next job 2*2 = 4 must start fresh
    send_cmd(8'd4, c);
    send_beat(8'd9, 8'd9, 8'd9, 8'd9, e);
    send_beat(8'd9, 8'd9, 8'd9, 8'd9, e);
    reset = 1'b1;
    tick();
    chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
    chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("abort_dsp_acc", 64'(dsp_accumulate), 64'd0);
    reset = 1'b0;
    tick();
    chk("abort_cmd_ready_back", 64'(bus.cmd_ready), 64'd1);
    send_cmd(8'd1, c);
    send_beat(8'd2, 8'd2, 8'd0, 8'd0, e);
    push_exp(27'd4, e + MAC_LAT + 1);
    chk("post_abort_first_acc", 64'(dsp_accumulate), 64'd0);

    n = 0;
    while (sb_q.size() != 0 && n < BOUND) begin
      tick();
      n++;
    end
    repeat (10) tick();
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
